mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage; consumes the execute stage's outputs (ALU result, store data, write-back controls) and drives the data bus.
- Performs word loads and stores through a req/ack bus handshake and stalls the upstream pipeline until the bus completes.
- Registers the write-back result and destination, which feed the register file and the ID-stage bypass path.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles before abort; used only with the optional feature; range 1..65535.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_i  in  1  upstream presents a valid instruction.
- result_i  in  32  ALU result; word address for load/store.
- MemData_i  in  32  store data.
- MemWrite_i  in  1  instruction is a store.
- MemToReg_i  in  1  instruction is a load; load data goes to register.
- ALUToReg_i  in  1  ALU result goes to register.
- WriteRegDst_i  in  5  destination register.
- stall_o  out  1  upstream must hold all inputs this cycle.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write, 0 = read.
- bus_addr_o  out  32  word address.
- bus_wdata_o  out  32  write data.
- bus_ack_i  in  1  bus completes the transaction this cycle.
- bus_rdata_i  in  32  read data; valid when bus_ack_i = 1.
- wbEn_o  out  1  registered register-write enable.
- wbDst_o  out  5  registered destination register.
- wbData_o  out  32  registered write-back data.
- err_o  out  1  sticky bus-timeout flag (optional feature).

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state goes to IDLE. All outputs are 0: wbEn_o, wbDst_o, wbData_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, err_o. stall_o is 0 in the first cycle after reset.
- Memory op: valid_i & (MemWrite_i | MemToReg_i).
- Conflicting controls: if MemWrite_i and MemToReg_i are both 1, the store wins and no write-back occurs.
- State IDLE:
  - Non-memory op: stall_o = 0. At the next edge: wbData_o <= result_i, wbDst_o <= WriteRegDst_i, wbEn_o <= ALUToReg_i & (WriteRegDst_i != 0). Latency 1 cycle.
  - Memory op: stall_o = 1. At the edge, latch address, store data, we, load flag and destination into internal regs, set wbEn_o <= 0, and go to BUSY.
  - valid_i = 0: wbEn_o <= 0 at the edge.
- State BUSY:
  - bus_req_o = 1; bus_we_o, bus_addr_o and bus_wdata_o come from the latches and are held stable until ack.
  - Inputs are ignored while in BUSY.
  - stall_o = ~bus_ack_i.
  - On bus_ack_i = 1 at the edge:
    - Load: wbData_o <= bus_rdata_i, wbDst_o <= latched destination, wbEn_o <= (latched destination != 0).
    - Store: wbEn_o <= 0.
    - Go to IDLE.
- bus_req_o, bus_we_o, bus_addr_o and bus_wdata_o are registered; bus_req_o rises 1 cycle after the op is accepted.
- bus_ack_i while not in BUSY is ignored.
- Minimum memory-op occupancy is 2 cycles (IDLE accept + 1 BUSY cycle), with stall_o high for 1 cycle.
- bus_addr_o and bus_wdata_o hold their last values in IDLE; bus_req_o = 0 in IDLE.
- Reset in BUSY: the transaction is abandoned and bus_req_o = 0 from the next cycle. A late bus_ack_i is ignored.
- Register 0 is never written (wbEn_o forced to 0).

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES without ack, at that edge: go to IDLE, bus_req_o <= 0, wbEn_o <= 0, err_o <= 1.
  - stall_o = 0 in that final cycle.
  - err_o is cleared only by rst.
- Without the macro: no counter; BUSY waits indefinitely; err_o is tied to 0.

Test Plan:
- ALU op, result_i=0x00000005, WriteRegDst_i=3, ALUToReg_i=1 -> next cycle wbEn_o=1, wbDst_o=3, wbData_o=5; stall_o=0 throughout.
- Load, result_i=0x100, WriteRegDst_i=7, ack 3 cycles after bus_req_o rises with bus_rdata_i=0xDEADBEEF -> bus_addr_o=0x100, bus_we_o=0, stall_o high for 4 cycles; after ack wbEn_o=1, wbDst_o=7, wbData_o=0xDEADBEEF.
- Store, result_i=0x20, MemData_i=0x1234, ack on the first BUSY cycle -> bus_we_o=1, bus_wdata_o=0x1234, stall_o=1 for 1 cycle, wbEn_o stays 0.
- ALU op to register 0 with result 0xFFFFFFFF -> wbEn_o=0; load to register 0 -> bus transaction occurs and wbEn_o=0.
- rst asserted during BUSY, then bus_ack_i=1 one cycle later -> bus_req_o=0, wbEn_o=0, stall_o=0, and no write-back.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> bus_req_o high for 4 cycles, then IDLE with err_o=1 and wbEn_o=0; err_o stays 1 until rst.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Memory-access pipeline stage. Word loads/stores via a req/ack
//            bus, upstream stall while busy, registered write-back outputs.
//            Optional bus timeout with sticky error: define MEM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] result_i,
    input  logic [31:0] MemData_i,
    input  logic        MemWrite_i,
    input  logic        MemToReg_i,
    input  logic        ALUToReg_i,
    input  logic [4:0]  WriteRegDst_i,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        wbEn_o,
    output logic [4:0]  wbDst_o,
    output logic [31:0] wbData_o,
    output logic        err_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_chk_timeout
        $error("mem_stage: TIMEOUT_CYCLES out of range 1..65535");
    end

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic       r_is_load;
    logic [4:0] r_dst;
    logic       r_bus_req;
    logic       r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic       r_wb_en;
    logic [4:0] r_wb_dst;
    logic [31:0] r_wb_data;

    logic w_mem_op;
    logic w_timeout;

    assign w_mem_op = valid_i & (MemWrite_i | MemToReg_i);

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_err;

    // Fires on the BUSY cycle whose edge would bring the count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == S_BUSY) & ~bus_ack_i & (r_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= 16'd0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (!bus_ack_i) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_mem_op) w_next_state = S_BUSY;
            S_BUSY:  if (bus_ack_i || w_timeout) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            S_IDLE:  stall_o = w_mem_op;
            S_BUSY:  stall_o = ~bus_ack_i & ~w_timeout;
            default: stall_o = 1'b0;
        endcase
    end

    // Bus latches double as the held bus outputs; write-back registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load   <= 1'b0;
            r_dst       <= 5'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_wb_en     <= 1'b0;
            r_wb_dst    <= 5'd0;
            r_wb_data   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= MemWrite_i;
                        r_bus_addr  <= result_i;
                        r_bus_wdata <= MemData_i;
                        // A store wins over a conflicting load flag.
                        r_is_load   <= MemToReg_i & ~MemWrite_i;
                        r_dst       <= WriteRegDst_i;
                        r_wb_en     <= 1'b0;
                    end else if (valid_i) begin
                        r_wb_data <= result_i;
                        r_wb_dst  <= WriteRegDst_i;
                        r_wb_en   <= ALUToReg_i & (WriteRegDst_i != 5'd0);
                    end else begin
                        r_wb_en <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        if (r_is_load) begin
                            r_wb_data <= bus_rdata_i;
                            r_wb_dst  <= r_dst;
                            r_wb_en   <= (r_dst != 5'd0);
                        end else begin
                            r_wb_en <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_wb_en   <= 1'b0;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_wb_en   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign wbEn_o      = r_wb_en;
    assign wbDst_o     = r_wb_dst;
    assign wbData_o    = r_wb_data;

endmodule
`default_nettype wire
